// File: rtl/spare_pattern_generator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spare_gen_pkg : shared modes, FSM encoding and width helper  (rev 1.0)   |
// +--------------------------------------------------------------------------+
package spare_gen_pkg;

  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S1     = 2'b01;
  localparam logic [1:0] S2     = 2'b10;
  localparam logic [1:0] S3     = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Never returns less than 1 so a 2-wide vector still gets a 1-bit index.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spare_pattern_generator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spare_pattern_generator_if : pattern output handshake bundle  (rev 1.0)  |
// +--------------------------------------------------------------------------+
interface spare_pattern_generator_if #(
  parameter int DSSS_W = 8,
  parameter int RLSS_W = 4,
  parameter int CNT_W  = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DSSS_W-1:0] DSSS;
  logic [RLSS_W-1:0] RLSS;
  logic              last;
  logic [CNT_W-1:0]  pat_idx;

  modport master (
    output out_valid, DSSS, RLSS, last, pat_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, DSSS, RLSS, last, pat_idx,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/spare_pattern_generator_comb_stepper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comb_stepper : weight-K combination walker over W bits, descending order |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module comb_stepper
  import spare_gen_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_clear,
  input  wire logic         i_load,
  input  wire logic         i_step,
  output logic [W-1:0]      o_pattern,
  output logic              o_is_final,
  output logic              o_carry
);

  localparam int          PW      = clog2(W);
  localparam logic [W-1:0] c_FIRST = ~W'((64'd1 << (W - K)) - 64'd1);
  localparam logic [W-1:0] c_FINAL = W'((64'd1 << K) - 64'd1);

  logic [PW-1:0] r_pos  [K];
  logic [PW-1:0] w_next [K];
  logic [W-1:0]  r_pat;
  logic [W-1:0]  w_next_pat;
  logic          w_found;
  int            w_m;
  int            w_pm;

  // Deepest movable position drops by one; everything below it packs right under it.
  always_comb begin
    w_found    = 1'b0;
    w_m        = 0;
    w_pm       = 0;
    w_next_pat = '0;
    for (int n = 0; n < K; n++) begin
      if (int'(r_pos[n]) > K - 1 - n) begin
        w_found = 1'b1;
        w_m     = n;
        w_pm    = int'(r_pos[n]);
      end
    end
    for (int n = 0; n < K; n++) begin
      if (!w_found)
        w_next[n] = PW'(W - 1 - n);
      else if (n < w_m)
        w_next[n] = r_pos[n];
      else
        w_next[n] = PW'(w_pm - 1 - (n - w_m));
      w_next_pat = w_next_pat | (W'(1) << w_next[n]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < K; n++) r_pos[n] <= PW'(W - 1 - n);
      r_pat <= '0;
    end else if (i_clear) begin
      r_pat <= '0;
    end else if (i_load) begin
      for (int n = 0; n < K; n++) r_pos[n] <= PW'(W - 1 - n);
      r_pat <= c_FIRST;
    end else if (i_step) begin
      r_pos <= w_next;
      r_pat <= w_next_pat;
    end
  end

  assign o_pattern  = r_pat;
  assign o_is_final = (r_pat == c_FINAL);
  assign o_carry    = i_step & o_is_final;

endmodule
`default_nettype wire

// File: rtl/spare_pattern_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spare_pattern_generator : DSSS (x RLSS) combination source, valid/ready  |
// | rev 1.0 ; optional pattern counter under macro PAT_CNT_EN                |
// +--------------------------------------------------------------------------+
module spare_pattern_generator
  import spare_gen_pkg::*;
#(
  parameter int DSSS_W = 8,
  parameter int DSSS_K = 4,
  parameter int RLSS_W = 4,
  parameter int RLSS_K = 2,
  parameter int CNT_W  = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start,
  input  wire logic [1:0]            spare_struct_type,
  output logic                       busy,
  output logic                       done,
  spare_pattern_generator_if.master  bus
);

  state_t            r_state;
  logic [1:0]        r_mode;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_nested;
  logic              w_launch;
  logic              w_final_acc;
  logic [DSSS_W-1:0] w_dsss_pat;
  logic [RLSS_W-1:0] w_rlss_pat;
  logic              w_dsss_final;
  logic              w_rlss_final;
  logic              w_dsss_carry;
  logic              w_rlss_carry;

  assign w_accept = r_valid & bus.out_ready;
  assign w_nested = (r_mode == S3);
  assign w_launch = (r_state == IDLE) & start & (spare_struct_type != S_NONE);

  // DSSS wraps only when the whole enumeration wraps, i.e. the last pattern was taken.
  assign w_final_acc = w_dsss_carry;

  comb_stepper #(
    .W (DSSS_W),
    .K (DSSS_K)
  ) u_dsss (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_final_acc),
    .i_load     (w_launch),
    .i_step     (w_accept & (!w_nested | w_rlss_carry)),
    .o_pattern  (w_dsss_pat),
    .o_is_final (w_dsss_final),
    .o_carry    (w_dsss_carry)
  );

  comb_stepper #(
    .W (RLSS_W),
    .K (RLSS_K)
  ) u_rlss (
    .clk        (clk),
    .rst        (rst),
    .i_clear    ((w_launch & (spare_struct_type != S3)) | w_final_acc),
    .i_load     (w_launch & (spare_struct_type == S3)),
    .i_step     (w_accept & w_nested),
    .o_pattern  (w_rlss_pat),
    .o_is_final (w_rlss_final),
    .o_carry    (w_rlss_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mode  <= S_NONE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state <= GEN;
            r_mode  <= spare_struct_type;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        GEN: begin
          if (w_final_acc) begin
            r_state <= FIN;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PAT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if ((r_state != GEN) || w_final_acc)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.pat_idx = r_cnt;
`else
  assign bus.pat_idx = '0;
`endif

  assign bus.out_valid = r_valid;
  assign bus.DSSS      = w_dsss_pat;
  assign bus.RLSS      = w_rlss_pat;
  assign bus.last      = r_valid & w_dsss_final & (!w_nested | w_rlss_final);
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spare_pattern_generator.sv
`default_nettype none
// Self-checking bench: start-up vector table, then randomized runs against a
// popcount-ordered combination list; second instance covers the K=W case.
module tb_spare_pattern_generator;

  localparam int DW = 8;
  localparam int DK = 4;
  localparam int RW = 4;
  localparam int RK = 2;
`ifdef PAT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
  } pat_t;

  typedef struct {
    logic          st;
    logic [1:0]    md;
    logic          rdy;
    logic          e_valid;
    logic          e_busy;
    logic          e_done;
    logic [DW-1:0] e_d;
    logic [RW-1:0] e_r;
    logic          e_last;
    int            e_idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       busy, done;
  logic       start2 = 1'b0;
  logic [1:0] mode2 = 2'b00;
  logic       busy2, done2;

  int   n_checks = 0;
  int   n_errors = 0;
  pat_t exp_q[$];
  vec_t tbl[11];

  spare_pattern_generator_if #(.DSSS_W(DW), .RLSS_W(RW), .CNT_W(16)) bus ();
  spare_pattern_generator_if #(.DSSS_W(5),  .RLSS_W(RW), .CNT_W(16)) bus5 ();

  spare_pattern_generator #(
    .DSSS_W(DW), .DSSS_K(DK), .RLSS_W(RW), .RLSS_K(RK), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .spare_struct_type(mode),
    .busy(busy), .done(done), .bus(bus.master)
  );

  spare_pattern_generator #(
    .DSSS_W(5), .DSSS_K(5), .RLSS_W(RW), .RLSS_K(RK), .CNT_W(16)
  ) dut5 (
    .clk(clk), .rst(rst), .start(start2), .spare_struct_type(mode2),
    .busy(busy2), .done(done2), .bus(bus5.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Descending numeric order of weight-K words equals the required lexicographic order.
  function automatic void build(input logic [1:0] md);
    int   dl[$];
    int   rl[$];
    pat_t p;
    exp_q.delete();
    for (int v = (1 << DW) - 1; v >= 0; v--) if ($countones(v) == DK) dl.push_back(v);
    for (int v = (1 << RW) - 1; v >= 0; v--) if ($countones(v) == RK) rl.push_back(v);
    foreach (dl[i]) begin
      p.d = DW'(dl[i]);
      if (md == 2'b11) begin
        foreach (rl[j]) begin
          p.r = RW'(rl[j]);
          exp_q.push_back(p);
        end
      end else begin
        p.r = '0;
        exp_q.push_back(p);
      end
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(bus.out_valid), 0);
    check({tag, ".busy"},  32'(busy), 0);
    check({tag, ".DSSS"},  32'(bus.DSSS), 0);
    check({tag, ".RLSS"},  32'(bus.RLSS), 0);
    check({tag, ".last"},  32'(bus.last), 0);
    check({tag, ".idx"},   32'(bus.pat_idx), 0);
  endtask

  task automatic abort_reset();
    start = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst_async.done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_abort.done", 32'(done), 0);
      check("post_abort.valid", 32'(bus.out_valid), 0);
    end
  endtask

  task automatic run_seq(input logic [1:0] md, input int ready_pct, input int abort_at, input bit poke);
    int   k;
    int   cyc;
    int   n;
    logic acc;
    build(md);
    n = exp_q.size();
    k = 0;
    cyc = 0;
    start = 1'b1;
    mode = md;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < n && cyc < n * 40 + 100) begin
      if (abort_at >= 0 && k == abort_at) begin
        abort_reset();
        return;
      end
      check("gen.valid", 32'(bus.out_valid), 1);
      check("gen.busy",  32'(busy), 1);
      check("gen.done",  32'(done), 0);
      check("gen.DSSS",  32'(bus.DSSS), 32'(exp_q[k].d));
      check("gen.RLSS",  32'(bus.RLSS), 32'(exp_q[k].r));
      check("gen.last",  32'(bus.last), 32'(k == n - 1));
      check("gen.idx",   32'(bus.pat_idx), CNT_ON ? 32'(k) : 32'd0);
      acc = ($urandom_range(0, 99) < ready_pct);
      bus.out_ready = acc;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    if (k < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: actual=%0d accepted required=%0d", k, n);
      return;
    end
    check("fin.done", 32'(done), 1);
    check_idle("fin");
    @(posedge clk); #1;
    check("fin+1.done", 32'(done), 0);
    check("fin+1.busy", 32'(busy), 0);
  endtask

  initial begin
    bus.out_ready  = 1'b0;
    bus5.out_ready = 1'b0;
    tbl = '{
      '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 0},
      '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 0},
      '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 4'hC, 1'b0, 0},
      '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 4'hC, 1'b0, 0},
      '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 4'hA, 1'b0, 1},
      '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 4'h9, 1'b0, 2},
      '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 4'h9, 1'b0, 2},
      '{1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 4'h6, 1'b0, 3},
      '{1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 4'h5, 1'b0, 4},
      '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 4'h3, 1'b0, 5},
      '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hE8, 4'hC, 1'b0, 6}
    };

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset.done", 32'(done), 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st;
      mode = tbl[i].md;
      bus.out_ready = tbl[i].rdy;
      @(posedge clk); #1;
      check("tbl.valid", 32'(bus.out_valid), 32'(tbl[i].e_valid));
      check("tbl.busy",  32'(busy), 32'(tbl[i].e_busy));
      check("tbl.done",  32'(done), 32'(tbl[i].e_done));
      check("tbl.DSSS",  32'(bus.DSSS), 32'(tbl[i].e_d));
      check("tbl.RLSS",  32'(bus.RLSS), 32'(tbl[i].e_r));
      check("tbl.last",  32'(bus.last), 32'(tbl[i].e_last));
      check("tbl.idx",   32'(bus.pat_idx), CNT_ON ? 32'(tbl[i].e_idx) : 32'd0);
    end
    abort_reset();

    run_seq(2'b01, 100, -1, 1'b0);
    run_seq(2'b11, 100, -1, 1'b0);
    run_seq(2'b01, 55,  -1, 1'b0);
    run_seq(2'b01, 100, 30, 1'b0);
    run_seq(2'b01, 100, -1, 1'b0);
    run_seq(2'b10, 60,  -1, 1'b1);
    run_seq(2'b11, 70,  -1, 1'b1);

    start = 1'b1;
    mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    check_idle("mode00");

    start2 = 1'b1;
    mode2 = 2'b01;
    bus5.out_ready = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("k_eq_w.valid", 32'(bus5.out_valid), 1);
    check("k_eq_w.DSSS",  32'(bus5.DSSS), 32'h1F);
    check("k_eq_w.RLSS",  32'(bus5.RLSS), 0);
    check("k_eq_w.last",  32'(bus5.last), 1);
    check("k_eq_w.idx",   32'(bus5.pat_idx), 0);
    bus5.out_ready = 1'b1;
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;
    check("k_eq_w.done",  32'(done2), 1);
    check("k_eq_w.valid_off", 32'(bus5.out_valid), 0);
    check("k_eq_w.DSSS_off",  32'(bus5.DSSS), 0);
    check("k_eq_w.busy_off",  32'(busy2), 0);
    @(posedge clk); #1;
    check("k_eq_w.done_end", 32'(done2), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spare_pattern_generator.md
Name: spare_pattern_generator

Overview:
- Parametrised successor to the fixed 8-choose-4 / 4-choose-2 spare-signal generator used for repair-structure stimulus.
- Enumerates every weight-K combination over a DSSS vector of width W, and optionally nests every weight-KR combination over an RLSS vector.
- Adds start/done control, a valid/ready output handshake with backpressure, a last-pattern flag and a pattern counter.
- Sits between the test controller and the spare-allocation/BIRA datapath.

Parameters:
- DSSS_W, 8, DSSS vector width; 2..32.
- DSSS_K, 4, set bits per DSSS pattern; 1..DSSS_W.
- RLSS_W, 4, RLSS vector width; 2..16.
- RLSS_K, 2, set bits per RLSS pattern; 1..RLSS_W.
- CNT_W, 16, pattern-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin enumeration.
- spare_struct_type  in  2  00 = none, 01/10 = DSSS only, 11 = DSSS x RLSS nested.
- out_ready  in  1  consumer accepts the current pattern.
- out_valid  out  1  DSSS/RLSS hold a valid pattern.
- DSSS  out  DSSS_W  current DSSS pattern.
- RLSS  out  RLSS_W  current RLSS pattern; all zero in DSSS-only mode.
- last  out  1  current pattern is the final one.
- busy  out  1  enumeration in progress.
- done  out  1  one-cycle pulse after the final pattern is accepted.
- pat_idx  out  CNT_W  index of the current pattern.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. DSSS, RLSS, out_valid, last, busy, done, pat_idx all 0. Reset mid-run aborts with no done pulse.
- State machine: IDLE -> GEN -> FIN -> IDLE.
  - IDLE: on start=1 with a nonzero mode, latch the mode, load the first combination and move to GEN. out_valid=1 and busy=1 from the next cycle. start with mode 00 is ignored.
  - GEN: out_valid=1. All outputs stay stable while out_ready=0. On accept (out_valid & out_ready) the next pattern appears the following cycle, giving 1 pattern/cycle throughput under continuous ready. On accepting the pattern with last=1, move to FIN and drop out_valid.
  - FIN: done=1 for exactly one cycle; busy=0, outputs 0; then IDLE.
- start is ignored while busy. spare_struct_type changes after latching are ignored until the next start.
- Combination order is descending lexicographic over a position array pos[0..K-1], with pos[0] the highest bit.
  - First pattern: bits W-1..W-K set.
  - Step: find the deepest m with pos[m] > K-1-m; pos[m] -= 1; pos[n] = pos[m]-(n-m) for n>m.
  - No such m: wrap to the first pattern and assert carry.
  - Final pattern: bits K-1..0 set.
- Nested mode: RLSS steps on every accept. DSSS steps only on RLSS carry, with RLSS wrapping to its first pattern.
- last = DSSS at its final pattern AND (DSSS-only mode OR RLSS at its final pattern).
- Pattern counts: DSSS-only C(DSSS_W,DSSS_K) = 70 at defaults; nested C(DSSS_W,DSSS_K)*C(RLSS_W,RLSS_K) = 420 at defaults.
- Degenerate case K=W: a single pattern (all ones) with last=1 immediately.
- pat_idx wraps modulo 2^CNT_W; no saturation.

Optional Feature:
- Macro PAT_CNT_EN.
  - Defined: pat_idx = 0 on the first pattern, +1 per accept, cleared in IDLE.
  - Undefined: counter logic is omitted and pat_idx is tied to 0. The port is always present.

Decomposition:
- Package spare_gen_pkg holds:
  - mode localparams S_NONE=2'b00, S1=2'b01, S2=2'b10, S3=2'b11;
  - state encoding IDLE/GEN/FIN;
  - a clog2 function used for position-index width.
- Sub-module comb_stepper (params W, K), instanced once for DSSS and once for RLSS.
  - Inputs: load, step.
  - Outputs: pattern vector, is_final, carry.
  - Holds the pos array and the next-combination logic.

Test Plan:
- Defaults, mode 01, start, out_ready=1 constant -> 70 accepts. First DSSS=8'hF0, second 8'hE8, final 8'h0F with last=1, done one cycle later. RLSS=0 throughout.
- Defaults, mode 11, ready=1 -> 420 patterns. First DSSS=8'hF0 RLSS=4'hC, then RLSS 4'hA, 4'h9, 4'h6, 4'h5, 4'h3, then DSSS=8'hE8 RLSS=4'hC. Final 8'h0F/4'h3 with last=1.
- Mode 01, out_ready toggled randomly -> outputs stable while ready=0. Sequence identical to scenario 1, with no skipped or duplicated patterns.
- rst asserted mid-run at pattern 30 -> all outputs 0 immediately, no done. A new start restarts from 8'hF0.
- start pulsed during GEN, and spare_struct_type changed mid-run -> both ignored, sequence unchanged. start with mode 00 -> stays IDLE.
- DSSS_W=5, DSSS_K=5, mode 01 -> single pattern 5'h1F with last=1; with PAT_CNT_EN, pat_idx=0, then done.
